dog_pingpong_ctrl: RTL and testbench

//   Ping-pong line-buffer scheduler in front of gs_filter_5x5. Writes the incoming pixel stream into two line RAMs
//   (bank0/bank1) alternately and reads the previously filled bank out to the filter. Guarantees that the filter's
//   ram0_valid_in/ram1_valid_in are never high together. Sequences one frame of LINES lines per start pulse.

---
 rtl/dog_pkg.sv | 17 +
 rtl/dog_line_cnt.sv | 37 +++
 rtl/dog_pingpong_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_dog_pingpong_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/dog_pkg.sv
// Shared types for the ping-pong line-buffer scheduler.
// State encoding of the frame sequencer and the line RAM read latency.
// Used by dog_pingpong_ctrl and its counters.
package dog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_STREAM,
    ST_LAST,
    ST_DRAIN
  } state_e;

  // Line RAM read data appears this many cycles after its read enable
  localparam int RAM_RD_LAT = 1;

endpackage

// File: rtl/dog_line_cnt.sv
// Modulo-N counter: counts 0..N-1, then returns to 0; clr has priority over inc.
// Latency: count updates on the clock edge after inc/clr.
// Backpressure: none; the caller gates inc.
module dog_line_cnt #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear, wrap at N-1, or step by one
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = (cnt_q == W'(N - 1)) ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == W'(N - 1));

endmodule

// File: rtl/dog_pingpong_ctrl.sv
// Ping-pong line-buffer scheduler: writes pixels into two line banks alternately, reads the other bank out.
// Latency: writes reach the RAM port 1 cycle after the transfer; ram*_valid trails ram*_re by 1 cycle.
// Backpressure: pix_ready drops while the write bank is full and the reader is still busy, and outside FILL/STREAM.
module dog_pingpong_ctrl
  import dog_pkg::*;
#(
  parameter int LINE_W = 256,
  parameter int AW     = 8,
  parameter int LINES  = 256,
  parameter int KERNEL = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          pix_valid,
  input  logic [7:0]    pix_data,
  output logic          pix_ready,
  output logic          ram0_we,
  output logic          ram1_we,
  output logic [AW-1:0] ram_waddr,
  output logic [7:0]    ram_wdata,
  output logic          ram0_re,
  output logic          ram1_re,
  output logic [AW-1:0] ram_raddr,
  output logic          ram0_valid,
  output logic          ram1_valid,
  output logic          line_done,
  output logic          frame_done,
  output logic          busy
);

  localparam int LCW = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int DCW = (KERNEL > 1) ? $clog2(KERNEL) : 1;

  state_e          state_q, state_d;
  logic            wr_bank_q, wr_bank_d;
  logic            wr_full_q, wr_full_d;
  logic            rd_done_q, rd_done_d;
  logic [DCW-1:0]  drain_q, drain_d;
  logic            we0_q, we0_d, we1_q, we1_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            valid0_q, valid0_d, valid1_q, valid1_d;

  logic            frame_start, swap, xfer, wr_last, rd_issue, rd_last;
  logic [AW-1:0]   wr_cnt, rd_cnt;
  logic            wr_tc, rd_tc, line_tc;
  // Only the last-line flag matters here; the line index itself is not consumed
  logic [LCW-1:0]  line_cnt_unused;

  dog_line_cnt #(.N(LINE_W), .W(AW)) u_wr_cnt (
    .clk(clk), .rst(rst), .inc(xfer), .clr(swap | frame_start),
    .cnt(wr_cnt), .tc(wr_tc)
  );

  dog_line_cnt #(.N(LINE_W), .W(AW)) u_rd_cnt (
    .clk(clk), .rst(rst), .inc(rd_issue), .clr(swap | frame_start),
    .cnt(rd_cnt), .tc(rd_tc)
  );

  dog_line_cnt #(.N(LINES), .W(LCW)) u_line_cnt (
    .clk(clk), .rst(rst), .inc(swap), .clr(frame_start),
    .cnt(line_cnt_unused), .tc(line_tc)
  );

  // Sequencer: next state, bank swap decision, line-complete flags and handshake outputs
  always_comb begin
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    wr_full_d   = wr_full_q;
    rd_done_d   = rd_done_q;
    drain_d     = '0;
    frame_start = 1'b0;
    swap        = 1'b0;
    frame_done  = 1'b0;

    pix_ready = (state_q == ST_FILL || state_q == ST_STREAM) && !wr_full_q;
    xfer      = pix_ready && pix_valid;
    wr_last   = xfer && wr_tc;
    rd_issue  = (state_q == ST_STREAM || state_q == ST_LAST) && !rd_done_q;
    rd_last   = rd_issue && rd_tc;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          frame_start = 1'b1;
          wr_bank_d   = 1'b0;
          state_d     = ST_FILL;
        end
      end
      ST_FILL: begin
        // Nothing is being read yet, so the first line swaps on its own
        if (wr_last) begin
          swap    = 1'b1;
          state_d = line_tc ? ST_LAST : ST_STREAM;
        end
      end
      ST_STREAM: begin
        // Swap once both sides are done with their line, whichever finished last
        if ((wr_full_q || wr_last) && (rd_done_q || rd_last)) begin
          swap = 1'b1;
          if (line_tc) state_d = ST_LAST;
        end
      end
      ST_LAST: begin
        if (rd_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_q == DCW'(KERNEL - 1)) begin
          frame_done = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (swap) begin
      wr_bank_d = ~wr_bank_q;
      wr_full_d = 1'b0;
      rd_done_d = 1'b0;
    end else begin
      if (wr_last) wr_full_d = 1'b1;
      if (rd_last && state_q == ST_STREAM) rd_done_d = 1'b1;
    end
  end

  // Read bank is always the one not being written
  assign ram0_re   = rd_issue && wr_bank_q;
  assign ram1_re   = rd_issue && !wr_bank_q;
  assign ram_raddr = rd_cnt;
  assign line_done = rd_last;
  assign busy      = (state_q != ST_IDLE);

  // Write port is registered one cycle after the transfer; valids track the RAM read latency
  always_comb begin
    we0_d    = xfer && !wr_bank_q;
    we1_d    = xfer && wr_bank_q;
    waddr_d  = xfer ? wr_cnt : waddr_q;
    wdata_d  = xfer ? pix_data : wdata_q;
    valid0_d = ram0_re;
    valid1_d = ram1_re;
  end

  // State and pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_bank_q <= 1'b0;
      wr_full_q <= 1'b0;
      rd_done_q <= 1'b0;
      drain_q   <= '0;
      we0_q     <= 1'b0;
      we1_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      valid0_q  <= 1'b0;
      valid1_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      wr_full_q <= wr_full_d;
      rd_done_q <= rd_done_d;
      drain_q   <= drain_d;
      we0_q     <= we0_d;
      we1_q     <= we1_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      valid0_q  <= valid0_d;
      valid1_q  <= valid1_d;
    end
  end

  assign ram0_we    = we0_q;
  assign ram1_we    = we1_q;
  assign ram_waddr  = waddr_q;
  assign ram_wdata  = wdata_q;
  assign ram0_valid = valid0_q;
  assign ram1_valid = valid1_q;

endmodule

// File: tb/tb_dog_pingpong_ctrl.sv
// Bench for dog_pingpong_ctrl with LINE_W=8, LINES=3, KERNEL=5 against a count-based frame model.
// Inputs change on the falling edge; outputs are compared on the following falling edge.
// The model tracks accepted pixels and issued reads and derives every handshake from them.
module tb_dog_pingpong_ctrl;

  localparam int LW     = 8;
  localparam int AW     = 4;
  localparam int LINES  = 3;
  localparam int KERNEL = 5;
  localparam int TOT    = LW * LINES;

  logic          clk = 1'b0;
  logic          rst, start, pix_valid;
  logic [7:0]    pix_data;
  logic          pix_ready, ram0_we, ram1_we, ram0_re, ram1_re;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [7:0]    ram_wdata;
  logic          ram0_valid, ram1_valid, line_done, frame_done, busy;

  always #5 clk = ~clk;

  dog_pingpong_ctrl #(.LINE_W(LW), .AW(AW), .LINES(LINES), .KERNEL(KERNEL)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .ram0_we(ram0_we), .ram1_we(ram1_we), .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata), .ram0_re(ram0_re), .ram1_re(ram1_re), .ram_raddr(ram_raddr),
    .ram0_valid(ram0_valid), .ram1_valid(ram1_valid), .line_done(line_done),
    .frame_done(frame_done), .busy(busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp_v, $time);
    end
  endtask

  // Frame model: pixels accepted (m_w) and reads issued (m_r) in the current frame
  bit         m_act;
  int         m_w, m_r, m_drain;
  bit         p_we, p_v0, p_v1;
  int         p_bank, p_addr;
  logic [7:0] p_dat;
  bit         e_rdy, e_rd, e_fd;

  // Line L may be written once line L-2 has been read out; line M may be read once it is fully written
  task automatic compute_exp();
    int ln;
    ln    = m_w / LW;
    e_rdy = m_act && (m_w < TOT) && (ln < 2 || m_r >= (ln - 1) * LW);
    e_rd  = m_act && (m_r < TOT) && (m_w >= (m_r / LW + 1) * LW);
    e_fd  = m_act && (m_r == TOT) && (m_drain == KERNEL - 1);
  endtask

  task automatic check_all();
    chk("busy", 32'(busy), 32'(m_act));
    chk("pix_ready", 32'(pix_ready), 32'(e_rdy));
    chk("ram0_re", 32'(ram0_re), 32'(e_rd && (m_r / LW) % 2 == 0));
    chk("ram1_re", 32'(ram1_re), 32'(e_rd && (m_r / LW) % 2 == 1));
    if (e_rd) chk("ram_raddr", 32'(ram_raddr), 32'(m_r % LW));
    chk("line_done", 32'(line_done), 32'(e_rd && (m_r % LW) == LW - 1));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("ram0_we", 32'(ram0_we), 32'(p_we && p_bank == 0));
    chk("ram1_we", 32'(ram1_we), 32'(p_we && p_bank == 1));
    if (p_we) begin
      chk("ram_waddr", 32'(ram_waddr), 32'(p_addr));
      chk("ram_wdata", 32'(ram_wdata), 32'(p_dat));
    end
    chk("ram0_valid", 32'(ram0_valid), 32'(p_v0));
    chk("ram1_valid", 32'(ram1_valid), 32'(p_v1));
    chk("re_exclusive", 32'(ram0_re & ram1_re), 32'(0));
  endtask

  task automatic model_step(input bit r, input bit s, input bit v, input logic [7:0] d);
    bit was_act, xf;
    if (r) begin
      m_act = 0; m_w = 0; m_r = 0; m_drain = 0;
      p_we = 0; p_v0 = 0; p_v1 = 0;
    end else begin
      was_act = m_act;
      xf      = e_rdy && v;
      p_we    = xf;
      if (xf) begin
        p_bank = (m_w / LW) % 2;
        p_addr = m_w % LW;
        p_dat  = d;
      end
      p_v0 = e_rd && (m_r / LW) % 2 == 0;
      p_v1 = e_rd && (m_r / LW) % 2 == 1;
      if (e_fd) m_act = 0;
      else if (m_act && m_r == TOT) m_drain++;
      if (xf) m_w++;
      if (e_rd) begin
        m_r++;
        m_drain = 0;
      end
      if (!was_act && s) begin
        m_act = 1; m_w = 0; m_r = 0; m_drain = 0;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit v, input logic [7:0] d);
    rst = r; start = s; pix_valid = v; pix_data = d;
    model_step(r, s, v, d);
    @(negedge clk);
    compute_exp();
    check_all();
  endtask

  task automatic reset_checks();
    chk("rst_waddr", 32'(ram_waddr), 32'(0));
    chk("rst_wdata", 32'(ram_wdata), 32'(0));
    chk("rst_raddr", 32'(ram_raddr), 32'(0));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1'($urandom_range(1)), 8'($urandom));
  endtask

  // mode 0: valid held, data = pixel index; mode 1: valid toggles; mode 2: random valid at pct %
  task automatic run_frame(input int mode, input int pct, input int abort_w, input bit noise);
    int   guard;
    bit   tog, v, s;
    logic [7:0] d;
    guard = 0;
    tog   = 1;
    cyc(0, 1, 0, 8'h00);
    while (m_act && guard < 2000) begin
      case (mode)
        0:       v = 1;
        1:       begin v = tog; tog = !tog; end
        default: v = ($urandom_range(99) < pct);
      endcase
      d = (mode == 0) ? 8'(m_w) : 8'($urandom);
      s = noise && ($urandom_range(9) == 0);
      if (abort_w >= 0 && m_w == abort_w) cyc(1, 0, v, d);
      else                                cyc(0, s, v, d);
      guard++;
    end
    chk("frame_end_idle", 32'(busy), 32'(0));
    if (abort_w >= 0) reset_checks();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; start = 0; pix_valid = 0; pix_data = 0;
    m_act = 0; m_w = 0; m_r = 0; m_drain = 0;
    p_we = 0; p_v0 = 0; p_v1 = 0; p_bank = 0; p_addr = 0; p_dat = 0;
    e_rdy = 0; e_rd = 0; e_fd = 0;
    @(negedge clk);
    cyc(1, 0, 0, 8'h00);
    cyc(1, 1, 1, 8'h55);
    cyc(1, 0, 0, 8'h00);
    reset_checks();
    idle_cycles(3);

    run_frame(0, 100, -1, 0);          // back-to-back pixels 0..23
    idle_cycles(4);
    run_frame(1, 100, -1, 0);          // valid toggling: reader finishes first
    idle_cycles(2);
    run_frame(2, 70, -1, 1);           // random valid with start pulses while busy
    idle_cycles(2);
    run_frame(2, 100, LW + 4, 0);      // reset in STREAM with wr_cnt=4
    idle_cycles(1);
    run_frame(0, 100, -1, 0);          // clean frame after the abort
    for (int i = 0; i < 6; i++) begin
      idle_cycles(int'($urandom_range(1, 4)));
      run_frame(2, int'($urandom_range(20, 100)), -1, 1);
    end
    idle_cycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
